revelar_cascada: RTL

- Game-state engine for the 8x8 minesweeper board. Sits between the bomb/number generators and the VGA renderer.
- Consumes the bomb matrix, the neighbour-count matrix, the cursor position and the select/flag buttons.
- Owns the per-cell game-state matrix shown on screen, flood-reveals zero regions with a queue-based BFS, and raises win/lose flags.

---
 rtl/revelar_cascada.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/revelar_cascada.sv
// -----------------------------------------------------------------------------
// revelar_cascada
//
// Game-state engine for an 8x8 minesweeper board. It owns the per-cell state
// matrix that the renderer draws. It handles reveal and flag button presses. A
// reveal on a zero-count cell starts a queue-based flood fill, which opens every
// connected zero region together with its numbered border. The engine also
// raises the sticky win and lose flags.
//
// Cell (x,y) has index i = y*8+x. It occupies bits [4*i+3:4*i] of every matrix.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   select         reveal button (level); only its rising edge acts
//   flag           flag button (level); only its rising edge acts
//   pos_x, pos_y   cursor column / row
//   numero_bombas  number of bombs on the board, used for the win test
//   mBombas        bomb matrix, 4 bits per cell, nonzero = bomb
//   mNum           neighbour bomb count per cell, 4 bits, 0..8
//   mJ             game-state matrix: 0 hidden, 1 revealed, 2 flagged,
//                  3 exploded
//   busy           flood fill in progress
//   perdio         game lost (sticky until rst)
//   gano           game won (sticky until rst)
//   revelados      number of revealed safe cells, 0..64
//
// Button semantics: a press is a rising edge, detected against a one-cycle
// registered history. Presses are accepted only while idle and the game is
// still open. Presses that arrive at any other time are dropped, not queued.
// If both buttons rise in the same cycle, the reveal wins.
//
// Flood timing: each popped cell costs one POP cycle plus eight NEIGH cycles,
// one per neighbour, whether or not that neighbour is on the board. The final
// POP finds the queue empty and ends the flood.
// -----------------------------------------------------------------------------
module revelar_cascada #(
  parameter int GRID   = 8,
  parameter int QDEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         select,
  input  logic         flag,
  input  logic [2:0]   pos_x,
  input  logic [2:0]   pos_y,
  input  logic [5:0]   numero_bombas,
  input  logic [255:0] mBombas,
  input  logic [255:0] mNum,
  output logic [255:0] mJ,
  output logic         busy,
  output logic         perdio,
  output logic         gano,
  output logic [6:0]   revelados
);

  localparam int CELLS = GRID * GRID;

  localparam logic [3:0] CELL_HIDDEN   = 4'd0;
  localparam logic [3:0] CELL_REVEALED = 4'd1;
  localparam logic [3:0] CELL_FLAGGED  = 4'd2;
  localparam logic [3:0] CELL_EXPLODED = 4'd3;

  // Neighbour offsets are held as 5-bit two's complement.
  localparam logic [4:0] OFF_M1 = 5'h1f;
  localparam logic [4:0] OFF_Z0 = 5'h00;
  localparam logic [4:0] OFF_P1 = 5'h01;

  typedef enum logic [1:0] {IDLE, POP, NEIGH, FIN} state_t;

  state_t      state;
  logic        select_d;
  logic        flag_d;
  logic [5:0]  cur;
  logic [2:0]  nbr;

  // Flood queue. A cell is pushed only when it is revealed, so the queue
  // never holds more than the 64 board cells.
  logic [5:0]  q_mem [QDEPTH];
  logic [5:0]  q_rd;
  logic [5:0]  q_wr;
  logic [6:0]  q_cnt;

  logic        sel_pe;
  logic        flg_pe;
  logic        accept;
  logic [5:0]  sel_idx;
  logic [3:0]  sel_cell;
  logic        sel_bomb;
  logic        sel_zero;

  logic [4:0]  dx;
  logic [4:0]  dy;
  logic [4:0]  nx;
  logic [4:0]  ny;
  logic        n_in;
  logic [5:0]  n_idx;
  logic [3:0]  n_cell;
  logic        n_bomb;
  logic        n_zero;
  logic        n_reveal;

  logic        push_en;
  logic [5:0]  push_idx;
  logic [6:0]  rev_inc;
  logic [6:0]  win_target;

  assign sel_pe  = select & ~select_d;
  assign flg_pe  = flag & ~flag_d;
  assign accept  = (state == IDLE) && !perdio && !gano;

  assign sel_idx  = {pos_y, pos_x};
  assign sel_cell = mJ[{sel_idx, 2'b00} +: 4];
  assign sel_bomb = |mBombas[{sel_idx, 2'b00} +: 4];
  assign sel_zero = (mNum[{sel_idx, 2'b00} +: 4] == 4'd0);

  // Walk order: row above (left to right), same row (left, right), row below.
  always_comb begin
    dx = OFF_Z0;
    dy = OFF_Z0;
    case (nbr)
      3'd0: begin dx = OFF_M1; dy = OFF_M1; end
      3'd1: begin dx = OFF_Z0; dy = OFF_M1; end
      3'd2: begin dx = OFF_P1; dy = OFF_M1; end
      3'd3: begin dx = OFF_M1; dy = OFF_Z0; end
      3'd4: begin dx = OFF_P1; dy = OFF_Z0; end
      3'd5: begin dx = OFF_M1; dy = OFF_P1; end
      3'd6: begin dx = OFF_Z0; dy = OFF_P1; end
      default: begin dx = OFF_P1; dy = OFF_P1; end
    endcase
  end

  // Coordinates are 0..7. Stepping off the board yields -1 (5'h1f) or
  // 8 (5'h08). Either case sets one of the two top bits.
  assign nx      = {2'b00, cur[2:0]} + dx;
  assign ny      = {2'b00, cur[5:3]} + dy;
  assign n_in    = (nx[4:3] == 2'b00) && (ny[4:3] == 2'b00);
  assign n_idx   = {ny[2:0], nx[2:0]};
  assign n_cell  = mJ[{n_idx, 2'b00} +: 4];
  assign n_bomb  = |mBombas[{n_idx, 2'b00} +: 4];
  assign n_zero  = (mNum[{n_idx, 2'b00} +: 4] == 4'd0);
  assign n_reveal = (state == NEIGH) && n_in && (n_cell == CELL_HIDDEN) && !n_bomb;

  assign push_en  = (accept && sel_pe && (sel_cell == CELL_HIDDEN) && !sel_bomb && sel_zero)
                  || (n_reveal && n_zero);
  assign push_idx = (state == NEIGH) ? n_idx : sel_idx;

  assign rev_inc    = revelados + 7'd1;
  assign win_target = 7'(CELLS) - {1'b0, numero_bombas};

  // Queue storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      q_mem[q_wr] <= push_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      select_d  <= 1'b0;
      flag_d    <= 1'b0;
      cur       <= 6'd0;
      nbr       <= 3'd0;
      q_rd      <= 6'd0;
      q_wr      <= 6'd0;
      q_cnt     <= 7'd0;
      mJ        <= '0;
      busy      <= 1'b0;
      perdio    <= 1'b0;
      gano      <= 1'b0;
      revelados <= 7'd0;
    end else begin
      select_d <= select;
      flag_d   <= flag;

      if (push_en) begin
        q_wr  <= q_wr + 6'd1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_pe) begin
              if (sel_cell == CELL_HIDDEN) begin
                if (sel_bomb) begin
                  mJ[{sel_idx, 2'b00} +: 4] <= CELL_EXPLODED;
                  perdio <= 1'b1;
                  state  <= FIN;
                end else begin
                  mJ[{sel_idx, 2'b00} +: 4] <= CELL_REVEALED;
                  revelados <= rev_inc;
                  if (sel_zero) begin
                    q_cnt <= q_cnt + 7'd1;
                    busy  <= 1'b1;
                    state <= POP;
                  end else if (rev_inc == win_target) begin
                    gano  <= 1'b1;
                    state <= FIN;
                  end
                end
              end
            end else if (flg_pe) begin
              if (sel_cell == CELL_HIDDEN) begin
                mJ[{sel_idx, 2'b00} +: 4] <= CELL_FLAGGED;
              end else if (sel_cell == CELL_FLAGGED) begin
                mJ[{sel_idx, 2'b00} +: 4] <= CELL_HIDDEN;
              end
            end
          end
        end

        POP: begin
          if (q_cnt == 7'd0) begin
            busy <= 1'b0;
            if (revelados == win_target) begin
              gano  <= 1'b1;
              state <= FIN;
            end else begin
              state <= IDLE;
            end
          end else begin
            cur   <= q_mem[q_rd];
            q_rd  <= q_rd + 6'd1;
            q_cnt <= q_cnt - 7'd1;
            nbr   <= 3'd0;
            state <= NEIGH;
          end
        end

        NEIGH: begin
          if (n_reveal) begin
            mJ[{n_idx, 2'b00} +: 4] <= CELL_REVEALED;
            revelados <= rev_inc;
            if (n_zero) begin
              q_cnt <= q_cnt + 7'd1;
            end
          end
          nbr <= nbr + 3'd1;
          if (nbr == 3'd7) begin
            state <= POP;
          end
        end

        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
